// File: rtl/serial_axis_sequencer.sv
// rtl/serial_axis_sequencer.sv - single-byte command decoder, axis sample capture and framed reply sequencer
module serial_axis_sequencer #(
    parameter int         SETTLE_CYCLES = 1024,
    parameter int         BUSY_TIMEOUT  = 8,
    parameter logic [7:0] HEADER        = 8'hA5,
    parameter logic [7:0] NAK           = 8'h15
) (
    input  logic        CLK_50,
    input  logic        dly_rst,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic [15:0] sample,
    output logic [2:0]  dimension,
    output logic        busy,
    output logic        cmd_overflow,
    output logic [7:0]  frame_count
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, SELECT, SETTLE, CAPTURE, LOAD, START, WAIT_HI, WAIT_LO, NEXT
    } stateT;

    stateT state, nextState;

    logic [SW-1:0] settleCnt;
    logic [TW-1:0] timeoutCnt;
    logic [2:0]    byteIdx;
    logic [7:0]    sampleL, sampleH;
    logic [1:0]    curAxis;
    logic          allAxes, nakFrame;
    logic          bufValid;
    logic [7:0]    bufData;

    logic          cmdValid, cmdKnown, cmdAll;
    logic [7:0]    cmdByte;
    logic [1:0]    cmdAxis;
    logic [7:0]    axisCode, checksum, frameByte;
    logic          lastByte, moreAxes;

    // A buffered command always takes priority over a fresh byte in IDLE.
    always_comb begin
        cmdValid = 1'b0;
        cmdByte  = rx_data;
        if (bufValid) begin
            cmdValid = 1'b1;
            cmdByte  = bufData;
        end else if (rx_ready) begin
            cmdValid = 1'b1;
        end
    end

    always_comb begin
        cmdKnown = 1'b1;
        cmdAxis  = 2'd0;
        cmdAll   = 1'b0;
        case (cmdByte)
            8'h78:   cmdAxis = 2'd0;
            8'h79:   cmdAxis = 2'd1;
            8'h7A:   cmdAxis = 2'd2;
            8'h61:   cmdAll  = 1'b1;
            default: cmdKnown = 1'b0;
        endcase
    end

    assign axisCode = 8'h78 + {6'd0, curAxis};
    assign checksum = axisCode ^ sampleL ^ sampleH;
    assign lastByte = nakFrame || (byteIdx == 3'd4);
    assign moreAxes = allAxes && (curAxis != 2'd2);

    always_comb begin
        frameByte = NAK;
        if (!nakFrame) begin
            case (byteIdx)
                3'd0:    frameByte = HEADER;
                3'd1:    frameByte = axisCode;
                3'd2:    frameByte = sampleL;
                3'd3:    frameByte = sampleH;
                default: frameByte = checksum;
            endcase
        end
    end

    always_ff @(posedge CLK_50 or posedge dly_rst) begin
        if (dly_rst) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        tx_start  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (cmdValid) nextState = cmdKnown ? SELECT : LOAD;
            SELECT:  nextState = SETTLE;
            SETTLE:  if (settleCnt == '0) nextState = CAPTURE;
            CAPTURE: nextState = LOAD;
            LOAD:    if (!tx_busy) nextState = START;
            START: begin
                tx_start  = 1'b1;
                nextState = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy)                          nextState = WAIT_LO;
                else if (timeoutCnt == TIMEOUT_LAST)  nextState = NEXT;
            end
            WAIT_LO: if (!tx_busy) nextState = NEXT;
            NEXT: begin
                if (!lastByte)     nextState = LOAD;
                else if (moreAxes) nextState = SELECT;
                else               nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or posedge dly_rst) begin
        if (dly_rst) begin
            settleCnt    <= '0;
            timeoutCnt   <= '0;
            byteIdx      <= '0;
            sampleL      <= '0;
            sampleH      <= '0;
            curAxis      <= '0;
            allAxes      <= 1'b0;
            nakFrame     <= 1'b0;
            bufValid     <= 1'b0;
            bufData      <= '0;
            tx_data      <= '0;
            dimension    <= '0;
            cmd_overflow <= 1'b0;
            frame_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmdValid) begin
                        curAxis  <= cmdAxis;
                        allAxes  <= cmdAll;
                        nakFrame <= !cmdKnown;
                        byteIdx  <= '0;
                    end
                end
                SELECT: begin
                    dimension <= {1'b0, curAxis};
                    settleCnt <= SETTLE_LAST;
                end
                SETTLE:  settleCnt <= settleCnt - SW'(1);
                CAPTURE: begin
                    sampleL <= sample[7:0];
                    sampleH <= sample[15:8];
                    byteIdx <= '0;
                end
                LOAD:    tx_data <= frameByte;
                START:   timeoutCnt <= '0;
                WAIT_HI: timeoutCnt <= timeoutCnt + TW'(1);
                NEXT: begin
                    if (!lastByte) begin
                        byteIdx <= byteIdx + 3'd1;
                    end else begin
                        frame_count <= frame_count + 8'd1;
                        if (moreAxes) curAxis <= curAxis + 2'd1;
                    end
                end
                default: ;
            endcase

            // Freeing the buffer and a new arrival in the same cycle refills it without loss.
            if (state == IDLE && bufValid) begin
                bufValid <= rx_ready;
                bufData  <= rx_data;
            end else if (rx_ready && state != IDLE) begin
                if (!bufValid) begin
                    bufValid <= 1'b1;
                    bufData  <= rx_data;
                end else begin
                    cmd_overflow <= 1'b1;
                end
            end
        end
    end
endmodule
